h_timing_generator: RTL and testbench

- Horizontal timing stage that sits directly upstream of the vertical sync generator.
- Counts pixel ticks across one scan line and drives four outputs: h_sync, an active-video flag, the pixel x-coordinate, and a one-cycle line_end pulse.
- line_end connects straight to the vertical sync generator's enable input.
- Clocked on control_clock; advances only on pixel_enable ticks.

---
 rtl/vga_timing_pkg.sv | 19 +
 rtl/h_timing_generator_if.sv | 27 ++
 rtl/enabled_wrap_counter.sv | 27 ++
 rtl/h_timing_generator.sv | 111 +++++++++++
 tb/tb_h_timing_generator.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: horizontal phase enum and default 640x480 horizontal constants.
// The vertical generator imports this package too.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    SYNC        = 2'd0,
    BACK_PORCH  = 2'd1,
    ACTIVE      = 2'd2,
    FRONT_PORCH = 2'd3
  } h_state_t;

  localparam int H_COUNTER_SIZE    = 11;
  localparam int H_SYNC_LEN        = 96;
  localparam int H_BACK_PORCH_LEN  = 48;
  localparam int H_ACTIVE_LEN      = 640;
  localparam int H_FRONT_PORCH_LEN = 16;
  localparam int H_LINE_LEN        = 800;

endpackage

// File: rtl/h_timing_generator_if.sv
// Signal bundle between the horizontal timing generator and its consumers.
// pixel_enable is a one-way tick qualifier (no ready/backpressure); every output is registered.
interface h_timing_generator_if #(
  parameter int COUNTER_SIZE = vga_timing_pkg::H_COUNTER_SIZE
);
  logic                    pixel_enable;
  logic                    h_sync;
  logic                    h_active;
  logic [COUNTER_SIZE-1:0] h_position;
  logic                    line_end;

  modport master (
    input  pixel_enable,
    output h_sync,
    output h_active,
    output h_position,
    output line_end
  );

  modport slave (
    output pixel_enable,
    input  h_sync,
    input  h_active,
    input  h_position,
    input  line_end
  );
endinterface

// File: rtl/enabled_wrap_counter.sv
// Enable-qualified up counter with synchronous reset that wraps from LAST to 0.
// wrap is combinational: high on an enabled cycle whose count is LAST.
module enabled_wrap_counter #(
  parameter int WIDTH = 11,
  parameter int LAST  = 799
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic at_last;

  assign at_last = (count == WIDTH'(LAST));
  assign wrap    = en && at_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= at_last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/h_timing_generator.sv
// Horizontal timing generator: SYNC -> BACK_PORCH -> ACTIVE -> FRONT_PORCH per scan line.
// Define H_TIMING_ACTIVE_LOW_SYNC_EN for negative-polarity h_sync (standard VGA).
module h_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int COUNTER_SIZE    = H_COUNTER_SIZE,
  parameter int SYNC_LEN        = H_SYNC_LEN,
  parameter int BACK_PORCH_LEN  = H_BACK_PORCH_LEN,
  parameter int ACTIVE_LEN      = H_ACTIVE_LEN,
  parameter int FRONT_PORCH_LEN = H_FRONT_PORCH_LEN,
  parameter int LINE_LEN        = H_LINE_LEN
) (
  input  logic                  control_clock,
  input  logic                  reset,
  h_timing_generator_if.master  bus,
  output h_state_t              state
);

  if (LINE_LEN != SYNC_LEN + BACK_PORCH_LEN + ACTIVE_LEN + FRONT_PORCH_LEN) begin : g_len_sum_check
    $fatal(1, "h_timing_generator: LINE_LEN %0d does not equal the sum of the phase lengths", LINE_LEN);
  end
  if (longint'(LINE_LEN) > (longint'(1) << COUNTER_SIZE)) begin : g_width_check
    $fatal(1, "h_timing_generator: LINE_LEN %0d does not fit in %0d bits", LINE_LEN, COUNTER_SIZE);
  end
  if (SYNC_LEN < 1 || BACK_PORCH_LEN < 1 || ACTIVE_LEN < 1 || FRONT_PORCH_LEN < 1) begin : g_phase_check
    $fatal(1, "h_timing_generator: every phase must be at least one tick long");
  end

`ifdef H_TIMING_ACTIVE_LOW_SYNC_EN
  localparam logic SYNC_ON = 1'b0;
`else
  localparam logic SYNC_ON = 1'b1;
`endif

  localparam logic [COUNTER_SIZE-1:0] SYNC_LAST   = COUNTER_SIZE'(SYNC_LEN - 1);
  localparam logic [COUNTER_SIZE-1:0] BP_LAST     = COUNTER_SIZE'(SYNC_LEN + BACK_PORCH_LEN - 1);
  localparam logic [COUNTER_SIZE-1:0] ACTIVE_LAST = COUNTER_SIZE'(SYNC_LEN + BACK_PORCH_LEN + ACTIVE_LEN - 1);

  logic [COUNTER_SIZE-1:0] count;
  logic                    wrap;
  logic                    h_sync_q;
  logic                    h_active_q;
  logic [COUNTER_SIZE-1:0] h_position_q;
  logic                    line_end_q;

  enabled_wrap_counter #(
    .WIDTH (COUNTER_SIZE),
    .LAST  (LINE_LEN - 1)
  ) u_line_counter (
    .clk   (control_clock),
    .rst   (reset),
    .en    (bus.pixel_enable),
    .count (count),
    .wrap  (wrap)
  );

  // Each phase exit sets the outputs for the first count of the next phase,
  // so outputs always describe the count the counter moves to on this edge.
  always_ff @(posedge control_clock) begin
    if (reset) begin
      state        <= SYNC;
      h_sync_q     <= SYNC_ON;
      h_active_q   <= 1'b0;
      h_position_q <= '0;
      line_end_q   <= 1'b0;
    end else begin
      line_end_q <= wrap;
      if (bus.pixel_enable) begin
        case (state)
          SYNC: begin
            if (count == SYNC_LAST) begin
              state    <= BACK_PORCH;
              h_sync_q <= ~SYNC_ON;
            end
          end
          BACK_PORCH: begin
            if (count == BP_LAST) begin
              state        <= ACTIVE;
              h_active_q   <= 1'b1;
              h_position_q <= '0;
            end
          end
          ACTIVE: begin
            if (count == ACTIVE_LAST) begin
              state        <= FRONT_PORCH;
              h_active_q   <= 1'b0;
              h_position_q <= '0;
            end else begin
              h_position_q <= h_position_q + 1'b1;
            end
          end
          FRONT_PORCH: begin
            if (wrap) begin
              state    <= SYNC;
              h_sync_q <= SYNC_ON;
            end
          end
          default: begin
            state <= SYNC;
          end
        endcase
      end
    end
  end

  assign bus.h_sync     = h_sync_q;
  assign bus.h_active   = h_active_q;
  assign bus.h_position = h_position_q;
  assign bus.line_end   = line_end_q;

endmodule

// File: tb/tb_h_timing_generator.sv
// Bench for h_timing_generator: default 640x480 instance plus a 4/2/8/2 instance,
// both driven by the same pixel_enable/reset and compared every cycle to a tick-count model.
module tb_h_timing_generator;
  import vga_timing_pkg::*;

  localparam int CS   = H_COUNTER_SIZE;
  localparam int S_CS = 5;

`ifdef H_TIMING_ACTIVE_LOW_SYNC_EN
  localparam logic SYNC_ON = 1'b0;
`else
  localparam logic SYNC_ON = 1'b1;
`endif

  logic     control_clock = 1'b0;
  logic     reset         = 1'b1;
  logic     pe            = 1'b0;
  h_state_t state;
  h_state_t state_s;

  h_timing_generator_if #(.COUNTER_SIZE(CS))   bus ();
  h_timing_generator_if #(.COUNTER_SIZE(S_CS)) bus_s ();

  assign bus.pixel_enable   = pe;
  assign bus_s.pixel_enable = pe;

  h_timing_generator dut (
    .control_clock (control_clock),
    .reset         (reset),
    .bus           (bus),
    .state         (state)
  );

  h_timing_generator #(
    .COUNTER_SIZE    (S_CS),
    .SYNC_LEN        (4),
    .BACK_PORCH_LEN  (2),
    .ACTIVE_LEN      (8),
    .FRONT_PORCH_LEN (2),
    .LINE_LEN        (16)
  ) dut_small (
    .control_clock (control_clock),
    .reset         (reset),
    .bus           (bus_s),
    .state         (state_s)
  );

  // clock / reset
  always #5 control_clock = ~control_clock;

  // scoreboard state
  int          checks    = 0;
  int          errors    = 0;
  int          c_main    = 0;
  int          c_small   = 0;
  int          le_pulses = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_s_q[$];

  // Expected output vector {phase, h_sync, h_active, line_end, h_position} for a line position c.
  function automatic logic [15:0] ref_out(int c, logic le, int sl, int bp, int al);
    int   ph;
    logic act;
    logic sy;
    logic [10:0] pos;
    if (c < sl)                ph = 0;
    else if (c < sl + bp)      ph = 1;
    else if (c < sl + bp + al) ph = 2;
    else                       ph = 3;
    act = (ph == 2);
    sy  = (ph == 0) ? SYNC_ON : ~SYNC_ON;
    pos = act ? 11'(c - sl - bp) : 11'd0;
    return {2'(ph), sy, act, le, pos};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [15:0] e;
    logic [15:0] es;
    e  = exp_q.pop_front();
    es = exp_s_q.pop_front();
    chk("state",        16'(state),          16'(e[15:14]));
    chk("h_sync",       16'(bus.h_sync),     16'(e[13]));
    chk("h_active",     16'(bus.h_active),   16'(e[12]));
    chk("line_end",     16'(bus.line_end),   16'(e[11]));
    chk("h_position",   16'(bus.h_position), 16'(e[10:0]));
    chk("s_state",      16'(state_s),          16'(es[15:14]));
    chk("s_h_sync",     16'(bus_s.h_sync),     16'(es[13]));
    chk("s_h_active",   16'(bus_s.h_active),   16'(es[12]));
    chk("s_line_end",   16'(bus_s.line_end),   16'(es[11]));
    chk("s_h_position", 16'(bus_s.h_position), 16'(es[10:0]));
    if (bus.line_end === 1'b1) le_pulses++;
  endtask

  // driver: one clock cycle with the given inputs, model update, then checks #1 after the edge
  task automatic cycle(input logic pe_in, input logic rst_in);
    logic le;
    logic le_s;
    pe    = pe_in;
    reset = rst_in;
    @(posedge control_clock);
    if (rst_in) begin
      c_main  = 0;
      c_small = 0;
      le      = 1'b0;
      le_s    = 1'b0;
    end else if (pe_in) begin
      le      = (c_main == H_LINE_LEN - 1);
      c_main  = (c_main + 1) % H_LINE_LEN;
      le_s    = (c_small == 15);
      c_small = (c_small + 1) % 16;
    end else begin
      le   = 1'b0;
      le_s = 1'b0;
    end
    exp_q.push_back(ref_out(c_main, le, H_SYNC_LEN, H_BACK_PORCH_LEN, H_ACTIVE_LEN));
    exp_s_q.push_back(ref_out(c_small, le_s, 4, 2, 8));
    #1;
    check_outputs();
  endtask

  initial begin
    // reset, with pe both low and high to show reset wins
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);

    // two lines at full rate
    le_pulses = 0;
    repeat (2 * H_LINE_LEN) cycle(1'b1, 1'b0);
    chk("pulses_full_rate", 16'(le_pulses), 16'd2);

    // one line with a tick every 4th cycle
    le_pulses = 0;
    repeat (H_LINE_LEN) begin
      cycle(1'b1, 1'b0);
      repeat (3) cycle(1'b0, 1'b0);
    end
    chk("pulses_sparse", 16'(le_pulses), 16'd1);

    // reset in the middle of ACTIVE
    repeat (500) cycle(1'b1, 1'b0);
    chk("mid_active_before_reset", 16'(bus.h_active), 16'd1);
    cycle(1'b1, 1'b1);
    chk("reset_state",      16'(state),          16'(SYNC));
    chk("reset_h_active",   16'(bus.h_active),   16'd0);
    chk("reset_h_position", 16'(bus.h_position), 16'd0);
    chk("reset_line_end",   16'(bus.line_end),   16'd0);
    chk("reset_h_sync",     16'(bus.h_sync),     16'(SYNC_ON));

    // stall 50 cycles at the last count of the line
    repeat (H_LINE_LEN - 1) cycle(1'b1, 1'b0);
    le_pulses = 0;
    repeat (50) cycle(1'b0, 1'b0);
    chk("hold_no_line_end", 16'(le_pulses), 16'd0);
    cycle(1'b1, 1'b0);
    chk("hold_wrap_line_end", 16'(bus.line_end), 16'd1);
    chk("hold_wrap_h_sync",   16'(bus.h_sync),   16'(SYNC_ON));
    cycle(1'b0, 1'b0);
    chk("hold_line_end_drops", 16'(bus.line_end), 16'd0);

    // random ticks with occasional reset
    repeat (3000) cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 199) == 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
